axi_mem_responder: RTL and testbench

- AXI4 responder (target) backed by on-chip memory; terminates one master port of the AXI interconnect.
- Used as a stand-in DRAM channel for sim/bring-up and as a scratchpad target behind the crossbar.
- Supports INCR bursts of up to 256 beats with 512-bit data and 16-bit IDs.
- Independent write (AW/W/B) and read (AR/R) engines; one outstanding transaction per direction.

---
 rtl/axi_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst responder backed by on-chip memory; independent write and read engines.
// Define AXI_RESP_ERRCNT_EN to enable the saturating SLVERR counter on err_cnt.
module axi_mem_responder #(
  parameter int unsigned MEM_LD = 10,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [511:0]      wdata,
  input  logic [63:0]       wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [15:0]       bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [15:0]       arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [15:0]       rid,
  output logic [511:0]      rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic [15:0]       err_cnt
);

  localparam int unsigned Lines = 1 << MEM_LD;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  w_state_e          r_wstate, w_wstate_nxt;
  r_state_e          r_rstate, w_rstate_nxt;
  logic              r_live;
  logic [15:0]       r_wid, r_rid;
  logic [MEM_LD-1:0] r_widx, r_ridx;
  logic [7:0]        r_wlen, r_rlen, r_rbeat;
  logic [8:0]        r_wbeat;
  logic              r_werr, r_rerr;
  logic [1:0]        r_bresp;
  logic [511:0]      r_rdata;
  logic [511:0]      r_mem [Lines];

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_err, w_ar_err, w_mem_we;
  logic w_unused;

  assign w_aw_err = |awaddr[ADDR_W-1:6+MEM_LD];
  assign w_ar_err = |araddr[ADDR_W-1:6+MEM_LD];
  assign w_unused = ^{awsize, arsize, awaddr[5:0], araddr[5:0]};

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  assign w_b_hs   = bvalid && bready;
  assign w_ar_hs  = arvalid && arready;
  assign w_r_hs   = rvalid && rready;
  assign w_mem_we = w_w_hs && !r_werr;

  assign bid   = r_wid;
  assign bresp = r_bresp;
  assign rid   = r_rid;
  assign rdata = r_rdata;
  assign rresp = {r_rerr, 1'b0};

  // r_live holds the address channels off while reset is asserted.
  always_comb begin
    w_wstate_nxt = r_wstate;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        awready = r_live;
        if (awvalid && r_live) w_wstate_nxt = WData;
      end
      WData: begin
        wready = 1'b1;
        if (wvalid && wlast) w_wstate_nxt = WResp;
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) w_wstate_nxt = WIdle;
      end
      default: w_wstate_nxt = WIdle;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        arready = r_live;
        if (arvalid && r_live) w_rstate_nxt = RFetch;
      end
      RFetch: w_rstate_nxt = RData;
      RData: begin
        rvalid = 1'b1;
        rlast  = (r_rbeat == r_rlen);
        if (rready) w_rstate_nxt = rlast ? RIdle : RFetch;
      end
      default: w_rstate_nxt = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= WIdle;
      r_rstate <= RIdle;
      r_live   <= 1'b0;
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= 2'b00;
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_live   <= 1'b1;
      if (w_aw_hs) begin
        r_wid   <= awid;
        r_widx  <= awaddr[6 +: MEM_LD];
        r_wlen  <= awlen;
        r_werr  <= w_aw_err;
        r_wbeat <= '0;
      end
      if (w_w_hs) begin
        r_widx  <= r_widx + 1'b1;
        r_wbeat <= r_wbeat + 1'b1;
        // Beat count mismatch: wlast arrived on a beat other than awlen+1.
        if (wlast) r_bresp <= (r_werr || (r_wbeat != {1'b0, r_wlen})) ? 2'b10 : 2'b00;
      end
      if (w_ar_hs) begin
        r_rid   <= arid;
        r_ridx  <= araddr[6 +: MEM_LD];
        r_rlen  <= arlen;
        r_rerr  <= w_ar_err;
        r_rbeat <= '0;
      end
      if (r_rstate == RFetch) r_rdata <= r_rerr ? '0 : r_mem[r_ridx];
      if (w_r_hs && !rlast) begin
        r_rbeat <= r_rbeat + 1'b1;
        r_ridx  <= r_ridx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 64; b++) begin
        if (wstrb[b]) r_mem[r_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

`ifdef AXI_RESP_ERRCNT_EN
  logic [15:0] r_err_cnt;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;

  always_comb begin
    w_err_inc = {1'b0, w_b_hs && r_bresp[1]} + {1'b0, w_r_hs && rlast && r_rerr};
    w_err_sum = {1'b0, r_err_cnt} + {15'b0, w_err_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else        r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised scoreboard bench for axi_mem_responder against a line-array memory model.
module tb_axi_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  awid, arid, bid, rid, err_cnt;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [511:0] wdata, rdata;
  logic [63:0]  wstrb;
  logic [1:0]   bresp, rresp;

  axi_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [15:0] id; logic [511:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t       bq[$];
  r_exp_t       rq[$];
  logic [511:0] model_mem [1024];
  logic [511:0] wbuf [256];
  logic [63:0]  sbuf [256];
  int           n_checks = 0;
  int           n_pass = 0;
  int           exp_err = 0;
  logic         rr_rand = 1'b1;
  logic         rr_force = 1'b0;

  function automatic void chk(input string name, input logic [511:0] act,
                              input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk_errcnt(input string name);
`ifdef AXI_RESP_ERRCNT_EN
    chk(name, 512'(err_cnt), 512'(exp_err));
`else
    chk(name, 512'(err_cnt), 512'(0));
`endif
  endfunction

  function automatic void fill_rand(input int n, input logic full_strb);
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 16; w++) wbuf[k][32*w +: 32] = $urandom;
      sbuf[k] = full_strb ? '1 : {$urandom, $urandom};
    end
  endfunction

  task automatic do_write(input logic [15:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input int nbeats);
    logic       err;
    logic [9:0] idx;
    b_exp_t     e;
    err = |addr[63:16];
    idx = addr[15:6];
    for (int k = 0; k < nbeats; k++) begin
      if (!err) begin
        for (int b = 0; b < 64; b++)
          if (sbuf[k][b]) model_mem[idx][8*b +: 8] = wbuf[k][8*b +: 8];
      end
      idx++;
    end
    e.id   = id;
    e.resp = (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    if (e.resp[1]) exp_err++;
    bq.push_back(e);
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'($urandom);
    for (int n = 0; n < 200; n++) begin @(negedge clk); if (awready) break; end
    chk("aw_ready", 512'(awready), 512'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == nbeats - 1);
      for (int n = 0; n < 200; n++) begin @(negedge clk); if (wready) break; end
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
    end
    for (int n = 0; n < 500 && bq.size() != 0; n++) @(negedge clk);
    chk("b_done", 512'(bq.size()), 512'(0));
  endtask

  task automatic do_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    logic       err;
    logic [9:0] idx;
    r_exp_t     e;
    err = |addr[63:16];
    idx = addr[15:6];
    for (int k = 0; k <= int'(len); k++) begin
      e.id   = id;
      e.data = err ? '0 : model_mem[idx];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (k == int'(len));
      rq.push_back(e);
      idx++;
    end
    if (err) exp_err++;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = 3'($urandom);
    for (int n = 0; n < 200; n++) begin @(negedge clk); if (arready) break; end
    chk("ar_ready", 512'(arready), 512'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk); chk("r_lat_fetch", 512'(rvalid), 512'(0));
    @(negedge clk); chk("r_lat_first", 512'(rvalid), 512'(1));
    for (int n = 0; n < 3000 && rq.size() != 0; n++) @(negedge clk);
    chk("r_done", 512'(rq.size()), 512'(0));
  endtask

  // Ready drivers
  initial begin
    rready = 1'b0; bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rready = rr_rand ? ($urandom_range(3) != 0) : rr_force;
      bready = ($urandom_range(2) != 0);
    end
  end

  // Monitor: pops expected responses on handshakes and checks holds under backpressure.
  initial begin
    logic         r_hold, b_hold, hold_last;
    logic [511:0] hold_data;
    logic [1:0]   hold_resp;
    b_exp_t       be;
    r_exp_t       re;
    r_hold = 1'b0; b_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_hold = 1'b0; b_hold = 1'b0;
      end else begin
        if (r_hold) begin
          chk("r_hold_valid", 512'(rvalid), 512'(1));
          chk("r_hold_data", rdata, hold_data);
          chk("r_hold_last", 512'(rlast), 512'(hold_last));
          chk("r_hold_resp", 512'(rresp), 512'(hold_resp));
        end
        if (b_hold) chk("b_hold_valid", 512'(bvalid), 512'(1));
        if (bvalid && bready) begin
          if (bq.size() == 0) chk("b_unexpected", 512'(bvalid), 512'(0));
          else begin
            be = bq.pop_front();
            chk("bid", 512'(bid), 512'(be.id));
            chk("bresp", 512'(bresp), 512'(be.resp));
          end
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) chk("r_unexpected", 512'(rvalid), 512'(0));
          else begin
            re = rq.pop_front();
            chk("rid", 512'(rid), 512'(re.id));
            chk("rdata", rdata, re.data);
            chk("rresp", 512'(rresp), 512'(re.resp));
            chk("rlast", 512'(rlast), 512'(re.last));
          end
        end
        r_hold = rvalid && !rready; hold_data = rdata; hold_last = rlast; hold_resp = rresp;
        b_hold = bvalid && !bready;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a0, a1;
    logic [7:0]  len;
    int          op;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0;
    #2;
    chk("rst_awready", 512'(awready), 512'(0));
    chk("rst_arready", 512'(arready), 512'(0));
    chk("rst_bvalid", 512'(bvalid), 512'(0));
    chk("rst_rvalid", 512'(rvalid), 512'(0));
    chk("rst_rlast", 512'(rlast), 512'(0));
    chk("rst_bid", 512'(bid), 512'(0));
    chk("rst_rid", 512'(rid), 512'(0));
    chk("rst_bresp", 512'(bresp), 512'(0));
    chk("rst_rresp", 512'(rresp), 512'(0));
    chk("rst_rdata", rdata, 512'(0));
    chk("rst_err_cnt", 512'(err_cnt), 512'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_rst_awready", 512'(awready), 512'(1));
    chk("post_rst_arready", 512'(arready), 512'(1));

    // Bring lines 0..31 and 1020..1023 to a known zero state.
    for (int k = 0; k < 32; k++) begin wbuf[k] = '0; sbuf[k] = '1; end
    do_write(16'h1, 64'h0, 8'd31, 32);
    do_write(16'h2, 64'(1020) << 6, 8'd3, 4);

    // Four-beat burst of k, read back with a different ID.
    for (int k = 0; k < 4; k++) begin wbuf[k] = 512'(k); sbuf[k] = '1; end
    do_write(16'd5, 64'h40, 8'd3, 4);
    do_read(16'd9, 64'h40, 8'd3);

    // Single-byte strobe over a zero line.
    wbuf[0] = 512'h5A5A_0000_00AB; sbuf[0] = 64'h1;
    do_write(16'h33, 64'h80, 8'd0, 1);
    do_read(16'h34, 64'h80, 8'd0);

    // Out-of-range start address on both channels; lines 0/1 must stay intact.
    fill_rand(2, 1'b1);
    do_write(16'h44, 64'(1) << 16, 8'd1, 2);
    do_read(16'h45, 64'(1) << 16, 8'd1);
    do_read(16'h46, 64'h0, 8'd1);
    @(negedge clk);
    chk_errcnt("err_cnt_after_addr_err");

    // Burst from the last line wraps to line 0.
    fill_rand(2, 1'b1);
    do_write(16'h50, 64'(1023) << 6, 8'd1, 2);
    do_read(16'h51, 64'(1023) << 6, 8'd1);

    // Early wlast: three beats against awlen=3, then a normal write is still accepted.
    fill_rand(3, 1'b0);
    do_write(16'h60, 64'(8) << 6, 8'd3, 3);
    fill_rand(1, 1'b1);
    do_write(16'h61, 64'(9) << 6, 8'd0, 1);
    do_read(16'h62, 64'(8) << 6, 8'd3);

    for (int it = 0; it < 24; it++) begin
      op  = int'($urandom_range(2));
      len = 8'($urandom_range(7));
      a0  = {48'h0, 10'($urandom_range(15)), 6'($urandom)};
      if ($urandom_range(7) == 0) a0[16 + $urandom_range(47)] = 1'b1;
      fill_rand(int'(len) + 1, $urandom_range(1) == 0);
      if (op == 0) do_write(16'($urandom), a0, len, int'(len) + 1);
      else if (op == 1) do_read(16'($urandom), a0, len);
      else begin
        a0 = {48'h0, 10'($urandom_range(7)), 6'($urandom)};
        a1 = {48'h0, 10'(16 + $urandom_range(7)), 6'($urandom)};
        fork
          do_write(16'($urandom), a0, len, int'(len) + 1);
          do_read(16'($urandom), a1, 8'($urandom_range(7)));
        join
      end
    end
    @(negedge clk);
    chk_errcnt("err_cnt_after_random");

    // rready held low for 10 cycles on the first beat.
    rr_rand = 1'b0; rr_force = 1'b0;
    fork
      do_read(16'h77, 64'(5) << 6, 8'd2);
      begin
        for (int n = 0; n < 100 && !rvalid; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        rr_rand = 1'b1;
      end
    join

    // Reset pulsed while a read beat is pending.
    rr_rand = 1'b0; rr_force = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 16'hAA; araddr = 64'(3) << 6; arlen = 8'd3;
    for (int n = 0; n < 200; n++) begin @(negedge clk); if (arready) break; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int n = 0; n < 100 && !rvalid; n++) @(negedge clk);
    chk("pre_rst_rvalid", 512'(rvalid), 512'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 512'(rvalid), 512'(0));
    chk("mid_rst_arready", 512'(arready), 512'(0));
    chk("mid_rst_rdata", rdata, 512'(0));
    chk("mid_rst_err_cnt", 512'(err_cnt), 512'(0));
    exp_err = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rr_rand = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rel_arready", 512'(arready), 512'(1));
    chk("rel_awready", 512'(awready), 512'(1));
    do_read(16'hAB, 64'(3) << 6, 8'd3);
    @(negedge clk);
    chk_errcnt("err_cnt_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
